// File: rtl/fc1_csr_arb.sv
// Two-master round-robin arbiter for the FC1 CSR slave bus.
// One outstanding access at a time; a missing rd_data_v is turned into an error ack by a timeout.
module fc1_csr_arb #(
  parameter int AW      = 10,
  parameter int DW      = 64,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          csr_wr_en,
  output logic          csr_rd_en,
  output logic [AW-1:0] csr_addr,
  output logic [DW-1:0] csr_wr_data,
  input  logic [DW-1:0] csr_rd_data,
  input  logic          csr_rd_data_v,
  output logic [15:0]   timeout_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t        state;
  logic          last_grant;
  logic          gnt;
  logic          wr_q;
  logic [7:0]    timer;
  logic          sel;
  logic          done;
  logic          done_err;
  logic [DW-1:0] done_data;

  // Contention goes to whichever master was not served last.
  always_comb begin
    sel = m1_req;
    if (m0_req && m1_req) sel = ~last_grant;
  end

  // A slave response on the expiry cycle still wins over the timeout.
  always_comb begin
    done      = (state == WAIT) && (csr_rd_data_v || (timer == 8'd0));
    done_err  = !csr_rd_data_v;
    done_data = csr_rd_data_v ? csr_rd_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      wr_q        <= 1'b0;
      timer       <= 8'd0;
      csr_wr_en   <= 1'b0;
      csr_rd_en   <= 1'b0;
      csr_addr    <= '0;
      csr_wr_data <= '0;
      timeout_cnt <= 16'd0;
      m0_ack      <= 1'b0;
      m0_rdata    <= '0;
      m0_err      <= 1'b0;
      m1_ack      <= 1'b0;
      m1_rdata    <= '0;
      m1_err      <= 1'b0;
    end else begin
      csr_wr_en <= 1'b0;
      csr_rd_en <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt         <= sel;
            last_grant  <= sel;
            wr_q        <= sel ? m1_wr : m0_wr;
            csr_addr    <= sel ? m1_addr : m0_addr;
            csr_wr_data <= sel ? m1_wdata : m0_wdata;
            // Strobe is registered here so it is high for exactly the ISSUE cycle.
            csr_wr_en   <= sel ? m1_wr : m0_wr;
            csr_rd_en   <= sel ? !m1_wr : !m0_wr;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= 8'(TIMEOUT);
          state <= WAIT;
        end
        WAIT: begin
          if (done) begin
            state <= ACK;
            if (done_err && (timeout_cnt != 16'hFFFF)) timeout_cnt <= timeout_cnt + 16'd1;
            if (!gnt) begin
              m0_ack <= 1'b1;
              m0_err <= done_err;
              if (!wr_q) m0_rdata <= done_data;
            end else begin
              m1_ack <= 1'b1;
              m1_err <= done_err;
              if (!wr_q) m1_rdata <= done_data;
            end
          end else begin
            timer <= timer - 8'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
